fifo_credit_tx: RTL
===================

Name: fifo_credit_tx

Overview:
Credit-gated stream transmitter that sits upstream of the team's FIFO.
- The FIFO's write side has no ready/backpressure signal (IN_valid/IN_data only), so pushing into a full FIFO corrupts it. This block holds one credit per free FIFO slot and never pushes without a credit.
- The receiver returns one credit per pop, i.e. per OUT_valid && IN_ready on the FIFO side.
- Includes a flush sequence that stops intake and waits until every issued word has been drained by the receiver.

Parameters:
NUM, 128, receiver FIFO depth = initial credit count
WIDTH, 32, data word width

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
IN_data  input  WIDTH  upstream word
IN_valid  input  1  upstream word valid
OUT_ready  output  1  upstream may transfer this cycle
IN_creditRet  input  1  one-cycle pulse per word popped at the receiver
IN_flush  input  1  request drain; single-cycle or level, sampled in RUN only
OUT_valid  output  1  push strobe to receiver FIFO (its IN_valid)
OUT_data  output  WIDTH  push data to receiver FIFO (its IN_data)
OUT_credits  output  $clog2(NUM+1)  current credit count
OUT_flushDone  output  1  one-cycle pulse when drain completes
OUT_creditErr  output  1  sticky: credit returned beyond NUM

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high. All flops use posedge clk, posedge rst.
- Reset values:
  - OUT_valid=0, OUT_data=0
  - credits=NUM
  - OUT_flushDone=0, OUT_creditErr=0
  - state=RUN
- Reset may assert mid-transfer. All state returns to reset values immediately, with no drain. The receiver must be reset in the same cycle.
- OUT_ready is combinational from registered state only: (state==RUN) && (credits!=0). It never depends on IN_valid or IN_creditRet.
- Accept: accept = IN_valid && OUT_ready.
  - Next cycle: OUT_valid=1 and OUT_data=IN_data (latency 1).
  - With no accept: OUT_valid=0 next cycle and OUT_data holds its last value.
  - There is no backpressure on the push side; the credit guarantees a free slot.
- Credit update: credits_next = credits - accept + IN_creditRet.
  - Accept and creditRet in the same cycle leave the count unchanged.
  - A credit returned while credits==0 becomes usable the following cycle, when OUT_ready rises.
- Credit overflow: IN_creditRet with credits==NUM and no accept.
  - Counter stays at NUM.
  - OUT_creditErr sets and stays set until reset.
- Credits never underflow: accept is impossible at 0.
- State machine:
  - RUN: normal operation. IN_flush=1 -> DRAIN next cycle. An accept in the same cycle as IN_flush is still valid.
  - DRAIN: OUT_ready=0 and IN_flush is ignored. Go to DONE when credits==NUM and OUT_valid==0, both registered.
  - DONE: lasts one cycle with OUT_flushDone=1 and OUT_ready=0, then -> RUN.
  - If the flush is issued with credits already NUM and OUT_valid=0, the sequence is RUN -> DRAIN -> DONE -> RUN (pulse two cycles after the flush).
- Invariant checked by bench: NUM - credits equals pushes issued minus credits returned.

Decomposition:
- Package fifo_credit_pkg:
  - typedef enum logic[1:0] {RUN, DRAIN, DONE} CreditTxState_t
  - localparam-derived width helper for the credit counter ($clog2(NUM+1))
- One sub-module, credit_counter (params NUM):
  - Inputs: clk, rst, IN_dec, IN_inc.
  - Outputs: OUT_count, OUT_zero, OUT_full, OUT_overflow (sticky).
  - Reset value NUM, saturating at NUM.
  - Reusable later on the receiver side.
- Top holds the state FSM and the output register.

Test Plan (NUM=4, WIDTH=8, receiver = FIFO#(4,8)):
1. After reset: OUT_credits=4, OUT_ready=1, OUT_valid=0. Drive 0x11,0x12,0x13,0x14 back-to-back with no pops -> OUT_valid high 4 consecutive cycles with data 0x11..0x14, one cycle after each accept. Credits go 3,2,1,0 and OUT_ready=0 once credits=0. The held 5th word 0x15 is not accepted.
2. From credits=0, pulse IN_creditRet once -> OUT_credits=1 next cycle. 0x15 is accepted that cycle and appears on OUT_data one cycle later. Credits return to 0.
3. At credits=2, accept and IN_creditRet in the same cycle -> OUT_credits stays 2. OUT_valid=1 next cycle.
4. Three words outstanding (credits=1), IN_flush for 1 cycle with IN_valid held high -> OUT_ready=0 from the next cycle. Return 3 credits on separate cycles -> credits=4. OUT_flushDone pulses exactly once, the cycle after DRAIN sees credits=4. OUT_ready=1 the following cycle. The receiver FIFO holds no lost or duplicated data.
5. At credits=4 with idle input, pulse IN_creditRet -> OUT_creditErr=1 and OUT_credits=4. OUT_creditErr remains 1 through further normal traffic until rst.
6. Assert rst asynchronously mid-burst (credits=1, OUT_valid=1, state DRAIN) -> within the same cycle OUT_valid=0, OUT_data=0, OUT_credits=4, OUT_flushDone=0, OUT_creditErr=0. After release the state is RUN with OUT_ready=1.

Source files
------------

// File: rtl/fifo_credit_pkg.sv
// Shared types and helpers for the credit-gated FIFO transmitter.
package fifo_credit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } CreditTxState_t;

  // Width of a counter that must hold every value from 0 up to num inclusive.
  function automatic int credit_width(input int num);
    return $clog2(num + 1);
  endfunction

endpackage

// File: rtl/fifo_credit_tx_if.sv
// Upstream stream, receiver push/credit path and flush control of fifo_credit_tx.
interface fifo_credit_tx_if
  import fifo_credit_pkg::*;
#(
  parameter int NUM   = 128,
  parameter int WIDTH = 32
) ();

  localparam int CW = credit_width(NUM);

  logic [WIDTH-1:0] IN_data;
  logic             IN_valid;
  logic             OUT_ready;
  logic             IN_creditRet;
  logic             IN_flush;
  logic             OUT_valid;
  logic [WIDTH-1:0] OUT_data;
  logic [CW-1:0]    OUT_credits;
  logic             OUT_flushDone;
  logic             OUT_creditErr;

  // Environment side: supplies words, credits and flush requests.
  modport master (
    output IN_data, IN_valid, IN_creditRet, IN_flush,
    input  OUT_ready, OUT_valid, OUT_data, OUT_credits, OUT_flushDone, OUT_creditErr
  );

  // Transmitter side.
  modport slave (
    input  IN_data, IN_valid, IN_creditRet, IN_flush,
    output OUT_ready, OUT_valid, OUT_data, OUT_credits, OUT_flushDone, OUT_creditErr
  );

endinterface

// File: rtl/credit_counter.sv
// Saturating credit counter: starts full at NUM, decrements on use, increments on
// return, and raises a sticky overflow flag on a return that would exceed NUM.
module credit_counter
  import fifo_credit_pkg::*;
#(
  parameter int NUM = 128,
  localparam int CW = credit_width(NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IN_dec,
  input  logic          IN_inc,
  output logic [CW-1:0] OUT_count,
  output logic          OUT_zero,
  output logic          OUT_full,
  output logic          OUT_overflow
);

  localparam logic [CW-1:0] FULL_C = CW'(NUM);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          overflow_r;
  logic          overflow_hit_s;

  // Next count; a simultaneous use and return cancel out.
  always_comb begin
    count_next_s   = count_r;
    overflow_hit_s = 1'b0;
    if (IN_inc && !IN_dec) begin
      if (count_r == FULL_C) begin
        overflow_hit_s = 1'b1;
      end else begin
        count_next_s = count_r + ONE_C;
      end
    end else if (IN_dec && !IN_inc) begin
      if (count_r != ZERO_C) begin
        count_next_s = count_r - ONE_C;
      end else begin
        count_next_s = count_r;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r    <= FULL_C;
      overflow_r <= 1'b0;
    end else begin
      count_r    <= count_next_s;
      overflow_r <= overflow_r | overflow_hit_s;
    end
  end

  assign OUT_count    = count_r;
  assign OUT_zero     = (count_r == ZERO_C);
  assign OUT_full     = (count_r == FULL_C);
  assign OUT_overflow = overflow_r;

endmodule

// File: rtl/fifo_credit_tx.sv
// Credit-gated transmitter feeding a FIFO whose write side has no backpressure.
// A word is only taken from upstream while a credit (free receiver slot) exists,
// and a flush stops intake until every pushed word has been popped again.
module fifo_credit_tx
  import fifo_credit_pkg::*;
#(
  parameter int NUM   = 128,
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  fifo_credit_tx_if.slave bus
);

  localparam int CW = credit_width(NUM);

  CreditTxState_t   state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             flush_done_r;

  logic [CW-1:0]    count_s;
  logic             zero_s;
  logic             full_s;
  logic             overflow_s;
  logic             ready_s;
  logic             accept_s;

  // Ready depends only on registered state, never on this cycle's inputs.
  assign ready_s  = (state_r == RUN) && !zero_s;
  assign accept_s = bus.IN_valid && ready_s;

  credit_counter #(.NUM(NUM)) u_credit_counter (
    .clk         (clk),
    .rst         (rst),
    .IN_dec      (accept_s),
    .IN_inc      (bus.IN_creditRet),
    .OUT_count   (count_s),
    .OUT_zero    (zero_s),
    .OUT_full    (full_s),
    .OUT_overflow(overflow_s)
  );

  // Push register and flush state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RUN;
      out_valid_r  <= 1'b0;
      out_data_r   <= {WIDTH{1'b0}};
      flush_done_r <= 1'b0;
    end else begin
      out_valid_r <= accept_s;
      if (accept_s) begin
        out_data_r <= bus.IN_data;
      end else begin
        out_data_r <= out_data_r;
      end
      case (state_r)
        RUN: begin
          flush_done_r <= 1'b0;
          if (bus.IN_flush) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          // Drained once all credits are home and no push is still in flight.
          if (full_s && !out_valid_r) begin
            state_r      <= DONE;
            flush_done_r <= 1'b1;
          end else begin
            state_r      <= DRAIN;
            flush_done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r      <= RUN;
          flush_done_r <= 1'b0;
        end
        default: begin
          state_r      <= RUN;
          flush_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.OUT_ready     = ready_s;
  assign bus.OUT_valid     = out_valid_r;
  assign bus.OUT_data      = out_data_r;
  assign bus.OUT_credits   = count_s;
  assign bus.OUT_flushDone = flush_done_r;
  assign bus.OUT_creditErr = overflow_s;

endmodule
